// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
//   Shared types and helpers for the parametrised serial pattern detector.
//   - state_t   : detector FSM states
//   - DEF_*     : default parameter values for the top level
//   - masked_eq : compares the low 'len' bits of two vectors
package seq_detect_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HUNT = 1'b1
   } state_t;

   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_CNT_W   = 16;

   // Compare width of masked_eq. It caps MAX_LEN at 64.
   localparam int CMP_W = 64;

   // The pattern is held LSB-aligned, so only bits [len-1:0] take part.
   function automatic logic masked_eq(input logic [CMP_W-1:0] a,
                                      input logic [CMP_W-1:0] b,
                                      input int               len);
      logic eq;
      eq = 1'b1;
      for (int i = 0; i < CMP_W; i++) begin
         if (i < len && a[i] != b[i]) eq = 1'b0;
      end
      return eq;
   endfunction

endpackage

// File: rtl/seq_detect_sat_cnt.sv
// seq_detect_sat_cnt
//   W-bit counter that saturates at all-ones, with a synchronous clear.
//   Ports:
//     clk  in  clock (rising edge)
//     rst  in  synchronous active-high reset
//     clr  in  synchronous clear. Same effect as rst.
//     inc  in  increment request. Ignored once the counter is saturated.
//     cnt  out current count
module seq_detect_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (inc && cnt != {W{1'b1}})
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Runtime-programmable serial bit-pattern detector. The pattern, its length
//   and the overlap mode sit in shadow registers that change only on CFG_LOAD.
//   MATCH pulses for one cycle after the edge that accepts the completing bit.
//   Build option: define SEQ_DETECT_CNT_EN to build the saturating MATCH_CNT
//   counter. Without it, MATCH_CNT is tied to 0.
//   Ports:
//     CLK       in   clock (rising edge)
//     RST       in   synchronous active-high reset
//     IN        in   serial data bit
//     IN_VALID  in   qualifies IN
//     CFG_LOAD  in   captures PAT/PAT_LEN/OVERLAP and clears history/count
//     PAT       in   pattern. PAT[PAT_LEN-1] is the first bit received.
//     PAT_LEN   in   pattern length, valid range 1..MAX_LEN
//     OVERLAP   in   1 = overlapping matches allowed
//     MATCH     out  registered hit pulse
//     MATCH_CNT out  saturating hit count
//     CFG_ERR   out  loaded PAT_LEN was out of range
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               IN,
   input  logic               IN_VALID,
   input  logic               CFG_LOAD,
   input  logic [MAX_LEN-1:0] PAT,
   input  logic [LEN_W-1:0]   PAT_LEN,
   input  logic               OVERLAP,
   output logic               MATCH,
   output logic [CNT_W-1:0]   MATCH_CNT,
   output logic               CFG_ERR
);

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic               err_q, err_d;
   logic               match_q;
   logic               hit;
   logic               len_ok;
   logic               accept;

   assign len_ok = (PAT_LEN != '0) && (PAT_LEN <= LEN_W'(MAX_LEN));
   // Bits arriving in ST_IDLE are dropped. CFG_LOAD wins over a coincident bit.
   assign accept = IN_VALID && !CFG_LOAD && (state_q == ST_HUNT);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         err_q   <= 1'b0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         err_q   <= err_d;
         match_q <= hit;
      end
   end

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      err_d   = err_q;
      hit     = 1'b0;

      if (CFG_LOAD) begin
         pat_d   = PAT;
         len_d   = PAT_LEN;
         ovl_d   = OVERLAP;
         hist_d  = '0;
         fill_d  = '0;
         state_d = len_ok ? ST_HUNT : ST_IDLE;
         err_d   = !len_ok;
      end else if (accept) begin
         // The low MAX_LEN bits of {HIST, IN} are the shifted history, so the
         // window is compared after the shift.
         hist_d = {hist_q[MAX_LEN-2:0], IN};
         if (fill_q != LEN_W'(MAX_LEN))
            fill_d = fill_q + LEN_W'(1);
         // The fill check stops a match from using stale zeros in the history
         // after a clear.
         if (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q} &&
             masked_eq(CMP_W'(hist_d), CMP_W'(pat_q), int'(len_q)))
            hit = 1'b1;
         if (hit && !ovl_q)
            fill_d = '0;
      end
   end

   assign MATCH   = match_q;
   assign CFG_ERR = err_q;

`ifdef SEQ_DETECT_CNT_EN
   seq_detect_sat_cnt #(
      .W   (CNT_W)
   ) u_cnt (
      .clk (CLK),
      .rst (RST),
      .clr (CFG_LOAD),
      .inc (hit),
      .cnt (MATCH_CNT)
   );
`else
   assign MATCH_CNT = '0;
`endif

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector, the next generation of the team's fixed-pattern sequence FSM. The pattern, its length and the overlap mode are runtime-programmable. Input bits are qualified by a valid strobe, and a saturating match counter is optional. It sits on a serial input stream and flags each completed occurrence of the programmed pattern to downstream control logic.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (>= 2)
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; do not override)
- CNT_W, 16, match counter width (>= 1)
- CLK  in  1  sole clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- IN  in  1  serial data bit
- IN_VALID  in  1  IN is sampled only when high
- CFG_LOAD  in  1  single-cycle pulse that captures the configuration inputs
- PAT  in  MAX_LEN  pattern; PAT[PAT_LEN-1] is the first bit received, PAT[0] the last
- PAT_LEN  in  LEN_W  pattern length; valid range 1..MAX_LEN
- OVERLAP  in  1  1 = overlapping matches allowed; 0 = history cleared after each match
- MATCH  out  1  registered one-cycle pulse per detected occurrence
- MATCH_CNT  out  CNT_W  saturating count of matches
- CFG_ERR  out  1  high while the loaded PAT_LEN is invalid

## Operation
- Shadow config registers hold the pattern, length and overlap mode. They change only on CFG_LOAD.
- FSM states:
  - ST_IDLE: no valid config; IN ignored.
  - ST_HUNT: detection active.
- CFG_LOAD with PAT_LEN in 1..MAX_LEN: go to ST_HUNT, CFG_ERR <= 0.
- CFG_LOAD with any other PAT_LEN: go to ST_IDLE, CFG_ERR <= 1.
- CFG_LOAD from either state also clears the history, the fill count and MATCH_CNT.
- History HIST[MAX_LEN-1:0]: on an accepted bit, HIST <= {HIST[MAX_LEN-2:0], IN}.
- Fill count FILL: counts bits accepted since the last clear, saturating at MAX_LEN.
- Hit condition, evaluated on an accepted bit:
  - the state is ST_HUNT,
  - FILL+1 >= len, and
  - the low len bits of {HIST, IN} equal PAT[len-1:0].
- A hit registers MATCH <= 1 for the next cycle; otherwise MATCH <= 0.
- After a hit with OVERLAP=0, FILL <= 0, so the next match needs len fresh bits.
- After a hit with OVERLAP=1, FILL continues counting.
- MATCH_CNT increments on each hit and holds at 2^CNT_W-1.
- Simultaneous CFG_LOAD and IN_VALID: CFG_LOAD wins. The bit is discarded and no hit is evaluated.
- IN_VALID low: history, FILL and the FSM hold; MATCH is 0 that cycle.
- len = 1: every accepted bit equal to PAT[0] is a hit. OVERLAP has no effect.

## Timing
- Reset values (next edge with RST high):
  - state ST_IDLE; HIST, FILL and shadow config all 0
  - MATCH = 0, MATCH_CNT = 0, CFG_ERR = 0
- RST takes priority over CFG_LOAD and IN_VALID.
- RST mid-stream discards partial history. No match may complete using bits accepted before reset.
- Detection latency: MATCH is high in the cycle after the edge that accepts the completing bit. MATCH_CNT updates on that same edge.
- Config latency: the first bit accepted on the cycle after CFG_LOAD is bit 1 of the new pattern.
- Back-to-back valid bits: a MATCH pulse is possible every cycle (OVERLAP=1).

## Configuration
- Macro: SEQ_DETECT_CNT_EN.
- Defined: the saturating MATCH_CNT counter is built as specified.
- Undefined: no counter flops are instantiated and MATCH_CNT is tied to 0. All other behaviour is identical.

## Structure
- Package seq_detect_pkg holds:
  - the state enum (ST_IDLE, ST_HUNT)
  - default constants for MAX_LEN and CNT_W
  - a function computing the length-masked compare
- One sub-module, seq_detect_sat_cnt, holds the CNT_W-bit saturating counter with synchronous clear. It is instantiated only under SEQ_DETECT_CNT_EN.

## Test plan
- Load PAT=5'b10011, PAT_LEN=5, OVERLAP=0, then send 1,0,0,1,1 valid on consecutive cycles -> MATCH=1 exactly one cycle after the 5th bit; MATCH_CNT=1.
- Load PAT=2'b11, PAT_LEN=2, send 1,1,1,1 -> OVERLAP=1 gives 3 MATCH pulses (count 3); OVERLAP=0 gives 2 pulses (count 2).
- Load PAT=5'b10011, PAT_LEN=5 and send the same bits with IN_VALID low between them, plus IN toggling while IN_VALID is low -> exactly one MATCH, after the 5th valid bit.
- Load PAT_LEN=0, then PAT_LEN=MAX_LEN+1 -> CFG_ERR=1 in both cases; no MATCH for any stream. A following valid load gives CFG_ERR=0.
- Load PAT=5'b10011, PAT_LEN=5 and send 1,0,0,1. Then:
  - assert RST for one cycle, reload, send 1 -> no MATCH.
  - alternatively, assert CFG_LOAD together with IN_VALID on the final bit -> no MATCH; MATCH_CNT=0.
- CNT_W=2, PAT_LEN=1, PAT=1, send six 1s -> six MATCH pulses; MATCH_CNT stops at 3. With SEQ_DETECT_CNT_EN undefined, MATCH_CNT stays 0.
